rtc_pixel_generator: RTL and testbench

//  Pixel stage directly downstream of the 640x480 VGA sync generator. Consumes pixel_X/pixel_Y,

---
 rtl/rtc_pixel_generator_pkg.sv | 51 +++++
 rtl/rtc_pixel_generator_if.sv | 24 ++
 rtl/font_rom_rtc.sv | 15 +
 rtl/rtc_pixel_generator.sv | 147 ++++++++++++++
 tb/tb_rtc_pixel_generator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pixel_generator_pkg.sv
// Shared constants and glyph helpers for the RTC text overlay on the 640x480 VGA path.
// Character codes, edit-field encodings and the segment-style 8x16 glyph generator live here.
package rtc_pixel_generator_pkg;

  localparam logic [3:0] CH_COLON = 4'd10;
  localparam logic [3:0] CH_BLANK = 4'd11;

  typedef enum logic [1:0] {
    EDIT_NONE    = 2'd0,
    EDIT_HOURS   = 2'd1,
    EDIT_MINUTES = 2'd2,
    EDIT_SECONDS = 2'd3
  } edit_t;

  function automatic logic [3:0] digit_code(input logic [3:0] nib);
    return (nib > 4'd9) ? CH_BLANK : nib;
  endfunction

  // Glyph row for an 8x16 cell; bit 7 is the leftmost column.
  // Digits are drawn as seven bars {a,b,c,d,e,f,g}; anything above the colon is empty.
  function automatic logic [7:0] glyph_row(input logic [3:0] code, input logic [3:0] row);
    logic [6:0] seg;
    logic [7:0] r;
    seg = 7'b0000000;
    r   = 8'h00;
    case (code)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    if (seg[6] && row >= 4'd1 && row <= 4'd2)  r = r | 8'h7E;
    if (seg[5] && row >= 4'd2 && row <= 4'd7)  r = r | 8'h06;
    if (seg[4] && row >= 4'd8 && row <= 4'd13) r = r | 8'h06;
    if (seg[3] && row >= 4'd13 && row <= 4'd14) r = r | 8'h7E;
    if (seg[2] && row >= 4'd8 && row <= 4'd13) r = r | 8'h60;
    if (seg[1] && row >= 4'd2 && row <= 4'd7)  r = r | 8'h60;
    if (seg[0] && row >= 4'd7 && row <= 4'd8)  r = r | 8'h7E;
    if (code == CH_COLON && (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11))
      r = 8'h18;
    return r;
  endfunction

endpackage

// File: rtl/rtc_pixel_generator_if.sv
// Pixel-stream bundle between the VGA sync generator, the RTC pixel stage and the pins.
interface rtc_pixel_generator_if;
  // Stream protocol: no backpressure; a pixel is valid once per rising edge of p_tick and
  // every consumer must accept it on that edge (the generator never waits).
  logic        p_tick;
  logic        video_on;
  logic [9:0]  pixel_X;
  logic [9:0]  pixel_Y;
  logic        sincro_horiz;
  logic        sincro_vert;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  modport master (
    output p_tick, video_on, pixel_X, pixel_Y, sincro_horiz, sincro_vert,
    input  rgb, hsync_out, vsync_out
  );

  modport slave (
    input  p_tick, video_on, pixel_X, pixel_Y, sincro_horiz, sincro_vert,
    output rgb, hsync_out, vsync_out
  );
endinterface

// File: rtl/font_rom_rtc.sv
// 256x8 synchronous glyph ROM, address {code[3:0], row[3:0]}; unused codes read zero.
module font_rom_rtc
  import rtc_pixel_generator_pkg::*;
(
  input  logic       CLK,
  input  logic       en,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  always_ff @(posedge CLK) begin
    if (en) data <= glyph_row(addr[7:4], addr[3:0]);
  end

endmodule

// File: rtl/rtc_pixel_generator.sv
// Renders "HH:MM:SS" as 2x-scaled 8x16 glyphs over a solid background, three pixel ticks
// behind the sync generator, with the syncs delayed through the same pipeline.
module rtc_pixel_generator
  import rtc_pixel_generator_pkg::*;
#(
  parameter int          TEXT_X       = 256,
  parameter int          TEXT_Y       = 224,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h00F,
  parameter int          BLINK_FRAMES = 30
)
(
  input  logic                  CLK,
  input  logic                  RESET,
  rtc_pixel_generator_if.slave  vid,
  input  logic [23:0]           time_bcd,
  input  logic [1:0]            edit_field
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic signed [10:0] TX = 11'(TEXT_X);
  localparam logic signed [10:0] TY = 11'(TEXT_Y);

  logic              p_tick_q, vs_q, adv, vs_fall;
  logic [23:0]       sh_time;
  edit_t             sh_edit;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink;

  logic signed [10:0] dx, dy;
  logic               in_box, blank_sel;
  logic [2:0]         char_idx, gcol;
  logic [3:0]         grow, code;

  logic [3:0] a_code, a_grow;
  logic [2:0] a_gcol, b_gcol;
  logic       a_in_box, a_video, a_hs, a_vs;
  logic       b_in_box, b_video, b_hs, b_vs;
  logic [7:0] rom_data;

  assign adv     = vid.p_tick & ~p_tick_q;
  assign vs_fall = vs_q & ~vid.sincro_vert;

  // Time and edit state are sampled only at the VSYNC falling edge so a frame never tears.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      p_tick_q  <= 1'b0;
      vs_q      <= 1'b0;
      sh_time   <= 24'h000000;
      sh_edit   <= EDIT_NONE;
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      p_tick_q <= vid.p_tick;
      vs_q     <= vid.sincro_vert;
      if (vs_fall) begin
        sh_time <= time_bcd;
        sh_edit <= edit_t'(edit_field);
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Signed 11-bit offsets keep pixels left of / above the box from aliasing into it.
  assign dx       = $signed({1'b0, vid.pixel_X}) - TX;
  assign dy       = $signed({1'b0, vid.pixel_Y}) - TY;
  assign in_box   = (dx >= 11'sd0) && (dx < 11'sd128) && (dy >= 11'sd0) && (dy < 11'sd32);
  assign char_idx = dx[6:4];
  assign gcol     = dx[3:1];
  assign grow     = dy[4:1];

  always_comb begin
    code      = CH_BLANK;
    blank_sel = 1'b0;
    case (char_idx)
      3'd0:    code = digit_code(sh_time[23:20]);
      3'd1:    code = digit_code(sh_time[19:16]);
      3'd3:    code = digit_code(sh_time[15:12]);
      3'd4:    code = digit_code(sh_time[11:8]);
      3'd6:    code = digit_code(sh_time[7:4]);
      3'd7:    code = digit_code(sh_time[3:0]);
      default: code = CH_COLON;
    endcase
    case (sh_edit)
      EDIT_HOURS:   blank_sel = (char_idx == 3'd0) || (char_idx == 3'd1);
      EDIT_MINUTES: blank_sel = (char_idx == 3'd3) || (char_idx == 3'd4);
      EDIT_SECONDS: blank_sel = (char_idx == 3'd6) || (char_idx == 3'd7);
      default:      blank_sel = 1'b0;
    endcase
    if (!in_box || (blink && blank_sel)) code = CH_BLANK;
  end

  font_rom_rtc u_font_rom (
    .CLK  (CLK),
    .en   (adv),
    .addr ({a_code, a_grow}),
    .data (rom_data)
  );

  // Stage A registers geometry, stage B lines up with the ROM read, stage C drives the pins.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_code        <= CH_BLANK;
      a_grow        <= 4'd0;
      a_gcol        <= 3'd0;
      a_in_box      <= 1'b0;
      a_video       <= 1'b0;
      a_hs          <= 1'b1;
      a_vs          <= 1'b1;
      b_gcol        <= 3'd0;
      b_in_box      <= 1'b0;
      b_video       <= 1'b0;
      b_hs          <= 1'b1;
      b_vs          <= 1'b1;
      vid.rgb       <= 12'h000;
      vid.hsync_out <= 1'b1;
      vid.vsync_out <= 1'b1;
    end else if (adv) begin
      a_code        <= code;
      a_grow        <= grow;
      a_gcol        <= gcol;
      a_in_box      <= in_box;
      a_video       <= vid.video_on;
      a_hs          <= vid.sincro_horiz;
      a_vs          <= vid.sincro_vert;
      b_gcol        <= a_gcol;
      b_in_box      <= a_in_box;
      b_video       <= a_video;
      b_hs          <= a_hs;
      b_vs          <= a_vs;
      if (!b_video)
        vid.rgb <= 12'h000;
      else if (b_in_box && rom_data[3'd7 - b_gcol])
        vid.rgb <= FG_COLOR;
      else
        vid.rgb <= BG_COLOR;
      vid.hsync_out <= b_hs;
      vid.vsync_out <= b_vs;
    end
  end

endmodule

// File: tb/tb_rtc_pixel_generator.sv
// Directed bench for rtc_pixel_generator: reset, glyph rendering, frame shadowing, blink, sync delay.
module tb_rtc_pixel_generator;

  localparam int          TX = 256;
  localparam int          TY = 224;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h00F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] time_bcd;
  logic [1:0]  edit_field;
  int          phase;
  int          checks = 0;
  int          failures = 0;

  rtc_pixel_generator_if vid ();

  rtc_pixel_generator dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .vid        (vid),
    .time_bcd   (time_bcd),
    .edit_field (edit_field)
  );

  // Clock and pixel tick: p_tick high two CLK out of four.
  always #5 clk = ~clk;

  initial begin
    phase      = 3;
    vid.p_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase      = (phase + 1) % 4;
      vid.p_tick = (phase < 2);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns 2 time units after a posedge on which the DUT sees the p_tick rising edge.
  task automatic wait_adv();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (phase == 1) break;
    end
  endtask

  task automatic drive_pixel(input int x, input int y, input logic von);
    wait_adv();
    vid.pixel_X  = x[9:0];
    vid.pixel_Y  = y[9:0];
    vid.video_on = von;
  endtask

  task automatic pixel_check(input string tag, input int x, input int y, input logic von,
                             input logic [11:0] exp);
    drive_pixel(x, y, von);
    repeat (3) wait_adv();
    check_eq(tag, vid.rgb, exp);
  endtask

  task automatic frame();
    @(posedge clk);
    #2 vid.sincro_vert = 1'b0;
    repeat (3) @(posedge clk);
    #2 vid.sincro_vert = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic sync_delay(input string tag, input bit vert, input logic val);
    int   n;
    logic o;
    wait_adv();
    if (vert) vid.sincro_vert = val;
    else      vid.sincro_horiz = val;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      n++;
      o = vert ? vid.vsync_out : vid.hsync_out;
      if (o === val) break;
    end
    check_eq(tag, n, 12);
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    finish_run();
  end

  initial begin
    bit blink_exp;
    rst_n            = 1'b0;
    vid.video_on     = 1'b0;
    vid.pixel_X      = 10'd0;
    vid.pixel_Y      = 10'd0;
    vid.sincro_horiz = 1'b1;
    vid.sincro_vert  = 1'b1;
    time_bcd         = 24'h000000;
    edit_field       = 2'd0;
    repeat (5) @(posedge clk);
    #2;
    check_eq("rst_rgb", vid.rgb, 12'h000);
    check_eq("rst_hs", vid.hsync_out, 1'b1);
    check_eq("rst_vs", vid.vsync_out, 1'b1);
    rst_n = 1'b1;

    // Basic rendering after one frame event.
    time_bcd = 24'h123456;
    frame();
    pixel_check("bg_origin", 0, 0, 1'b1, BG);
    drive_pixel(TX + 38, TY + 8, 1'b1);
    wait_adv();
    wait_adv();
    check_eq("colon_lat2", vid.rgb, BG);
    wait_adv();
    check_eq("colon_lat3", vid.rgb, FG);
    pixel_check("colon_gcol0", TX + 32, TY + 8, 1'b1, BG);
    pixel_check("video_off", TX + 38, TY + 8, 1'b0, 12'h000);
    pixel_check("h1_one_col5", TX + 10, TY + 6, 1'b1, FG);
    pixel_check("h1_one_col1", TX + 2, TY + 6, 1'b1, BG);
    pixel_check("m1_three_top", TX + 54, TY + 2, 1'b1, FG);
    pixel_check("below_box", TX + 10, TY + 38, 1'b1, BG);
    pixel_check("right_of_box", TX + 138, TY + 6, 1'b1, BG);
    pixel_check("left_of_box", TX - 118, TY + 6, 1'b1, BG);

    // Asynchronous reset in the middle of a frame.
    vid.sincro_horiz = 1'b0;
    pixel_check("pre_rst_rgb", 0, 0, 1'b1, BG);
    check_eq("pre_rst_hs", vid.hsync_out, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("midrst_rgb", vid.rgb, 12'h000);
    check_eq("midrst_hs", vid.hsync_out, 1'b1);
    check_eq("midrst_vs", vid.vsync_out, 1'b1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    vid.sincro_horiz = 1'b1;
    pixel_check("shadow0_h1", TX + 2, TY + 6, 1'b1, FG);
    pixel_check("shadow0_h0", TX + 18, TY + 6, 1'b1, FG);

    // Time changes mid-frame must not show until the next frame event.
    time_bcd = 24'h123456;
    frame();
    pixel_check("t3_pre_h0", TX + 18, TY + 20, 1'b1, FG);
    pixel_check("t3_pre_h1", TX + 2, TY + 20, 1'b1, BG);
    time_bcd = 24'h235959;
    pixel_check("t3_hold_h0", TX + 18, TY + 20, 1'b1, FG);
    pixel_check("t3_hold_h1", TX + 2, TY + 20, 1'b1, BG);
    frame();
    pixel_check("t3_new_h0", TX + 18, TY + 20, 1'b1, BG);
    pixel_check("t3_new_h1", TX + 2, TY + 20, 1'b1, FG);

    // Invalid BCD nibble renders as blank.
    time_bcd = 24'hA23456;
    frame();
    pixel_check("t5_bad_col5", TX + 10, TY + 6, 1'b1, BG);
    pixel_check("t5_bad_col1", TX + 2, TY + 20, 1'b1, BG);
    pixel_check("t5_h0_two", TX + 18, TY + 20, 1'b1, FG);

    // Minutes blink with a 30-frame half period; other fields stay lit.
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    time_bcd   = 24'h123456;
    edit_field = 2'd2;
    for (int n = 1; n <= 60; n++) begin
      frame();
      if (n == 1 || n == 29 || n == 30 || n == 59 || n == 60) begin
        blink_exp = (n >= 30) && (n < 60);
        pixel_check($sformatf("t4_m1_f%0d", n), TX + 54, TY + 2, 1'b1, blink_exp ? BG : FG);
        pixel_check($sformatf("t4_m0_f%0d", n), TX + 66, TY + 6, 1'b1, blink_exp ? BG : FG);
        pixel_check($sformatf("t4_h0_f%0d", n), TX + 18, TY + 20, 1'b1, FG);
        pixel_check($sformatf("t4_s1_f%0d", n), TX + 98, TY + 6, 1'b1, FG);
      end
    end
    edit_field = 2'd0;

    // Sync outputs trail their inputs by three pixel ticks (12 CLK).
    sync_delay("hs_fall_delay", 1'b0, 1'b0);
    sync_delay("hs_rise_delay", 1'b0, 1'b1);
    sync_delay("vs_fall_delay", 1'b1, 1'b0);
    sync_delay("vs_rise_delay", 1'b1, 1'b1);

    finish_run();
  end

endmodule
